block_accumulator: RTL
======================

Name: block_accumulator

Overview:
Parametrised successor to the adder buffer. Sums a runtime-programmable number of partial-product blocks from the systolic array, lane by lane, into a LANES-wide result vector. Signals completion with accumulator_done and holds the result until the downstream writer accepts it. Adds signed/unsigned selection, wider accumulators, optional saturation, per-lane overflow flags and an in_ready/out_ready handshake.

Parameters:
LANES, 16, number of independent lanes (matrix block elements).
DATA_W, 16, width of each input lane.
ACC_W, 16, width of each accumulator lane; must be >= DATA_W.
SIGNED, 0, 1 = lanes are two's complement and are sign-extended; 0 = unsigned and zero-extended.
SATURATE, 0, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.
CNT_W, 8, width of block_count and of the internal block counter.

Ports:
clock  input  1  single clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
input_1  input  LANES*DATA_W  partial block; lane i = bits [i*DATA_W +: DATA_W].
systolic_done  input  1  input-valid strobe; a block is accepted on any rising edge with systolic_done=1 and in_ready=1.
block_count  input  CNT_W  number of blocks per result; latched on the first accept of a sequence.
out_ready  input  1  downstream accepts the result.
in_ready  output  1  block can be accepted (state != DONE).
busy  output  1  1 in ACCUM.
accumulator_done  output  1  result valid on out.
overflow  output  LANES  per-lane sticky overflow for the current result.
out  output  LANES*ACC_W  accumulated result; lane i = bits [i*ACC_W +: ACC_W].

Behaviour:
- Reset (reset=0 at an edge), from any state including mid-accumulation:
  - state=IDLE, all accumulators=0, counter=0, latched count=0.
  - out=0, overflow=0, accumulator_done=0, busy=0, in_ready=1.
  - The reset cycle overrides any systolic_done or out_ready in the same cycle.
- States: IDLE, ACCUM, DONE.
- IDLE, on accept:
  - acc[i] = ext(input_1[i]); overflow cleared; counter=1.
  - Latch N = (block_count==0) ? 1 : block_count.
  - N==1 -> DONE; otherwise -> ACCUM.
- ACCUM, on accept:
  - acc[i] += ext(input_1[i]); counter+1.
  - counter+1 == N -> DONE.
  - No accept -> hold; gaps of any length are allowed.
- DONE:
  - accumulator_done=1, in_ready=0, out holds acc.
  - systolic_done is ignored; the producer must stall on in_ready.
  - out_ready=1 -> IDLE next edge; accumulators are not cleared, out keeps its value until the next sequence's first accept.
- Latency: accumulator_done rises on the edge that accepts the Nth block. Sum is visible on out in that same cycle (registered, 1 cycle after input presented).
- Arithmetic:
  - ext() sign- or zero-extends DATA_W to ACC_W per SIGNED.
  - Overflow is detected on the ACC_W+1 bit sum:
    - unsigned: carry out.
    - signed: operands have the same sign and the result sign differs.
  - On overflow overflow[i] is set and stays set until the next sequence's first accept.
  - SATURATE=1: unsigned clamps to 2^ACC_W-1; signed clamps to max/min by operand sign.
  - SATURATE=0: result wraps.
  - Lanes are fully independent; no carries between lanes.
- block_count changes mid-sequence have no effect. Counter never exceeds N; CNT_W=8 allows N up to 255.
- The IDLE->ACCUM transition is back-to-back: an accept is possible in the cycle immediately after leaving DONE.

Test Plan:
1. Reset mid-ACCUM (after 2 of 4 blocks), hold reset=0 one edge -> all outputs 0, state IDLE. A new 1-block sequence then completes normally.
2. Defaults, block_count=2, two accepts of 0x000400E8...00DD0060 -> lane0=0x00C0, lane1=0x01BA, lane15=0x0008. accumulator_done=1 on the 2nd accept edge, overflow=0.
3. block_count=3, blocks separated by 0, 4 and 1 idle cycles -> done only after the 3rd accept; busy=1 throughout. block_count changed to 9 mid-run is ignored.
4. Hold out_ready=0 for 5 cycles in DONE with systolic_done=1 and input lane0=0x1111 -> out unchanged, in_ready=0, accumulator_done stays 1. Then out_ready=1 -> IDLE. Next block starts a fresh sum.
5. Lane0 0xFFF0 + 0x0020, N=2:
   - SATURATE=0 -> 0x0010, overflow[0]=1.
   - SATURATE=1 -> 0xFFFF, overflow[0]=1.
   - Other lanes show overflow=0.
6. SIGNED=1, ACC_W=20, lane0 0x8000 four times -> 0xE0000 (-131072), no overflow. block_count=0 -> done after a single accept.

Source files
------------

// File: rtl/block_accumulator.sv
// block_accumulator: sums a runtime-programmable number of partial-product blocks
// lane by lane into a LANES-wide result, then holds the result until it is accepted.
//
// Ports:
//   clock            single clock, rising edge
//   reset            synchronous active-low reset
//   input_1          partial block, lane i = [i*DATA_W +: DATA_W]
//   systolic_done    input-valid strobe (accepted when in_ready=1)
//   block_count      blocks per result, latched on the first accept (0 treated as 1)
//   out_ready        downstream accepts the result
//   in_ready         a block can be accepted (not in DONE)
//   busy             accumulating (ACCUM)
//   accumulator_done result valid on out
//   overflow         per-lane sticky overflow for the current result
//   out              accumulated result, lane i = [i*ACC_W +: ACC_W]
module block_accumulator #(
  parameter int unsigned LANES    = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned SIGNED   = 0,
  parameter int unsigned SATURATE = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LANES*DATA_W-1:0]  input_1,
  input  logic                     systolic_done,
  input  logic [CNT_W-1:0]         block_count,
  input  logic                     out_ready,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     accumulator_done,
  output logic [LANES-1:0]         overflow,
  output logic [LANES*ACC_W-1:0]   out
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       num_q, num_d;
  logic [LANES*ACC_W-1:0] acc_q, acc_d;
  logic [LANES-1:0]       ovf_q, ovf_d;

  logic [LANES*ACC_W-1:0] lane_sum;
  logic [LANES-1:0]       lane_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] din;
    logic [ACC_W-1:0]  ext;
    logic [ACC_W-1:0]  base;
    logic [ACC_W:0]    base_x, ext_x, sum;
    logic [ACC_W-1:0]  res;
    logic              ovf;

    assign din = input_1[i*DATA_W +: DATA_W];

    if (SIGNED != 0) begin : g_sext
      assign ext = ACC_W'($signed(din));
    end else begin : g_zext
      assign ext = ACC_W'(din);
    end

    // The first accept of a sequence starts from zero rather than the held result.
    assign base = (state_q == StIdle) ? '0 : acc_q[i*ACC_W +: ACC_W];

    // One guard bit: carry for unsigned, duplicated sign for signed.
    assign base_x = {(SIGNED != 0) & base[ACC_W-1], base};
    assign ext_x  = {(SIGNED != 0) & ext[ACC_W-1], ext};
    assign sum    = base_x + ext_x;

    always_comb begin
      if (SIGNED != 0) begin
        // Guard and sign bits disagree only when like-signed operands overflow.
        ovf = sum[ACC_W] ^ sum[ACC_W-1];
      end else begin
        ovf = sum[ACC_W];
      end
      res = sum[ACC_W-1:0];
      if ((SATURATE != 0) && ovf) begin
        if (SIGNED != 0) begin
          res = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
          res = '1;
        end
      end
    end

    assign lane_sum[i*ACC_W +: ACC_W] = res;
    assign lane_ovf[i]                = ovf;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (systolic_done) begin
          acc_d   = lane_sum;
          ovf_d   = '0;
          cnt_d   = CNT_W'(1);
          num_d   = (block_count == '0) ? CNT_W'(1) : block_count;
          state_d = (num_d == CNT_W'(1)) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (systolic_done) begin
          acc_d = lane_sum;
          ovf_d = ovf_q | lane_ovf;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == num_q) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Producer stalls on in_ready; systolic_done is ignored here.
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      num_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready         = (state_q != StDone);
  assign busy             = (state_q == StAccum);
  assign accumulator_done = (state_q == StDone);
  assign overflow         = ovf_q;
  assign out              = acc_q;

endmodule
